// File: rtl/timer_prog.sv
// Programmable up-counting timer with one-shot / auto-reload modes and a done pulse at terminal count.
// Optional tick prescaler compiled in with `define TIMER_PROG_PRESCALE_EN.
module timer_prog #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [WIDTH-1:0] terminal;
   logic             mode_periodic;
   logic             tick_c;

   // Elaboration-time guard on parameter ranges
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("timer_prog: WIDTH out of range 1-32");
   end
   if (PRESCALE < 2 || PRESCALE > 65535) begin : g_bad_prescale
      $error("timer_prog: PRESCALE out of range 2-65535");
   end

`ifdef TIMER_PROG_PRESCALE_EN
   localparam int unsigned PSC_W = $clog2(PRESCALE);

   logic [PSC_W-1:0] psc;
   logic             psc_wrap_c;

   assign psc_wrap_c = (psc == PSC_W'(PRESCALE - 1));
   assign tick_c     = enable && (state == RUN) && psc_wrap_c;

   // Counts enabled RUN cycles; restarts on any start or stop
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc <= '0;
      end else if (enable) begin
         if (stop || start) begin
            psc <= '0;
         end else if (state == RUN) begin
            psc <= psc_wrap_c ? '0 : psc + PSC_W'(1);
         end
      end
   end
`else
   assign tick_c = enable && (state == RUN);
`endif

   // Control FSM; stop outranks start, start outranks a coincident tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         terminal      <= '0;
         mode_periodic <= 1'b0;
      end else begin
         done <= 1'b0;
         if (enable) begin
            if (stop) begin
               state <= IDLE;
               busy  <= 1'b0;
               count <= '0;
            end else if (start) begin
               state         <= RUN;
               busy          <= 1'b1;
               count         <= '0;
               terminal      <= load_val;
               mode_periodic <= periodic;
            end else if (tick_c) begin
               if (count != terminal) begin
                  count <= count + WIDTH'(1);
               end else begin
                  done  <= 1'b1;
                  count <= '0;
                  if (!mode_periodic) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
         end
      end
   end

endmodule
